rp_8bit_fetch: RTL and testbench

Instruction fetch sequencer for the rp 8-bit (AVR-compatible) core. It drives a synchronous program memory with a fixed 1-cycle read latency and buffers the returned words. It assembles one- and two-word instructions and hands them to the decoder over a valid/ready handshake. It also applies skip requests (cpse/sbic/sbis/sbrc/sbrs) and branch redirects (jmp/rjmp/call/ret/ijmp/interrupt) coming back from execute.

---
 rtl/rp_8bit_fetch.sv | 145 ++++++++++++++
 tb/tb_rp_8bit_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_8bit_fetch.sv
// Instruction fetch sequencer for the rp 8-bit core: program memory reads, word buffering, 1/2-word assembly.
// Latency: 1-cycle memory read; first id_vld two cycles after reset release, then 1 instruction/cycle.
// Backpressure: id_rdy=0 holds the head stable and stops new reads once the buffer would fill.
// Optional macro RP_8BIT_FETCH_TWO_WORD_EN: when defined, jmp/call/lds/sts are assembled as 32-bit instructions.
module rp_8bit_fetch #(
  parameter int             PAW     = 11,
  parameter int             DEPTH   = 2,
  parameter logic [PAW-1:0] RST_VEC = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pmem_ren,
  output logic [PAW-1:0] pmem_adr,
  input  logic [15:0]    pmem_rdt,
  output logic           id_vld,
  input  logic           id_rdy,
  output logic [31:0]    id_ins,
  output logic           id_two,
  output logic [PAW-1:0] id_pc,
  input  logic           skp_req,
  input  logic           br_req,
  input  logic [PAW-1:0] br_adr
);

  localparam int CW = $clog2(DEPTH + 1);

  // Architectural fetch state
  logic [PAW-1:0] r_pc;
  logic           r_inf;
  logic [PAW-1:0] r_inf_adr;
  logic [CW-1:0]  r_cnt;
  logic           r_skp;

  // Word buffer, head always at index 0 so a 1- or 2-word pop is a shift
  logic [15:0]    r_wrd [DEPTH];
  logic [PAW-1:0] r_adr [DEPTH];

  // Combinational helpers
  logic           w_head_two;
  int             w_head_len;
  logic           w_head_ok;
  logic           w_hand;
  logic           w_skp_pop;
  int             w_pop;
  logic           w_push;
  int             w_cnt_nxt;
  logic [15:0]    w_wrd_nxt [DEPTH];
  logic [PAW-1:0] w_adr_nxt [DEPTH];

  // Decode the head word length and whether the whole instruction is buffered
  always_comb begin
    w_head_two = 1'b0;
`ifdef RP_8BIT_FETCH_TWO_WORD_EN
    // jmp/call: 1001_010?_????_11??, lds/sts: 1001_00??_????_0000
    w_head_two = (r_wrd[0] ==? 16'b1001_010?_????_11??) ||
                 (r_wrd[0] ==? 16'b1001_00??_????_0000);
`endif
    w_head_len = w_head_two ? 2 : 1;
    w_head_ok  = (int'(r_cnt) >= w_head_len);
  end

  // Handover, skip consumption, memory issue and the buffer pop/push amounts
  always_comb begin
    // A branch suppresses both delivery and skip consumption in its own cycle
    id_vld    = !rst && !br_req && !r_skp && w_head_ok;
    w_hand    = id_vld && id_rdy;
    w_skp_pop = !rst && !br_req && r_skp && w_head_ok;
    w_pop     = (w_hand || w_skp_pop) ? w_head_len : 0;
    // Data returning during a branch cycle belongs to the old stream and is dropped
    w_push    = r_inf && !br_req;
    // Issue only if the word can be guaranteed a slot when it returns
    pmem_ren  = !rst && (br_req || ((int'(r_cnt) - w_pop + int'(r_inf)) < DEPTH));
    pmem_adr  = br_req ? br_adr : r_pc;
  end

  // Present the buffered head instruction; zero whenever no complete head is held
  always_comb begin
    id_two = 1'b0;
    id_ins = '0;
    id_pc  = '0;
    if (!rst && w_head_ok) begin
      id_two       = w_head_two;
      id_ins[15:0] = r_wrd[0];
      if (w_head_two) begin
        id_ins[31:16] = r_wrd[1];
      end
      id_pc = r_adr[0];
    end
  end

  // Next buffer contents: shift out popped words, append the returning word after the survivors
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wrd_nxt[i] = r_wrd[i];
      w_adr_nxt[i] = r_adr[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j == i + w_pop) begin
          w_wrd_nxt[i] = r_wrd[j];
          w_adr_nxt[i] = r_adr[j];
        end
      end
      if (w_push && (i == int'(r_cnt) - w_pop)) begin
        w_wrd_nxt[i] = pmem_rdt;
        w_adr_nxt[i] = r_inf_adr;
      end
    end
    w_cnt_nxt = br_req ? 0 : (int'(r_cnt) - w_pop + int'(w_push));
  end

  // Control state: pc, inflight tracking, occupancy and the skip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RST_VEC;
      r_inf     <= 1'b0;
      r_inf_adr <= '0;
      r_cnt     <= '0;
      r_skp     <= 1'b0;
    end else begin
      if (pmem_ren) begin
        r_pc <= pmem_adr + PAW'(1);
      end
      r_inf     <= pmem_ren;
      r_inf_adr <= pmem_adr;
      r_cnt     <= CW'(w_cnt_nxt);
      // Branch drops any pending or simultaneous skip; a set flag ignores further requests
      if (br_req) begin
        r_skp <= 1'b0;
      end else if (w_skp_pop) begin
        r_skp <= 1'b0;
      end else if (skp_req) begin
        r_skp <= 1'b1;
      end
      assert (w_cnt_nxt <= DEPTH);
    end
  end

  // Buffer storage is pure datapath; stale entries are masked by the occupancy count
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_wrd[i] <= w_wrd_nxt[i];
      r_adr[i] <= w_adr_nxt[i];
    end
  end

endmodule

// File: tb/tb_rp_8bit_fetch.sv
module tb_rp_8bit_fetch;
  localparam int PA = 11;
  localparam int PB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: PAW=11
  logic          rst_a, ren_a, vld_a, rdy_a, two_a, skp_a, br_a;
  logic [PA-1:0] adr_a, pc_a, bra_a;
  logic [15:0]   rdt_a;
  logic [31:0]   ins_a;
  logic [15:0]   mem_a [0:(1<<PA)-1];

  rp_8bit_fetch #(.PAW(PA), .DEPTH(2), .RST_VEC(11'd0)) dut_a (
    .clk(clk), .rst(rst_a), .pmem_ren(ren_a), .pmem_adr(adr_a), .pmem_rdt(rdt_a),
    .id_vld(vld_a), .id_rdy(rdy_a), .id_ins(ins_a), .id_two(two_a), .id_pc(pc_a),
    .skp_req(skp_a), .br_req(br_a), .br_adr(bra_a));

  // Instance B: PAW=4, reset vector 14 to exercise wrap
  logic          rst_b, ren_b, vld_b, rdy_b, two_b, skp_b, br_b;
  logic [PB-1:0] adr_b, pc_b, bra_b;
  logic [15:0]   rdt_b;
  logic [31:0]   ins_b;
  logic [15:0]   mem_b [0:(1<<PB)-1];

  rp_8bit_fetch #(.PAW(PB), .DEPTH(2), .RST_VEC(4'd14)) dut_b (
    .clk(clk), .rst(rst_b), .pmem_ren(ren_b), .pmem_adr(adr_b), .pmem_rdt(rdt_b),
    .id_vld(vld_b), .id_rdy(rdy_b), .id_ins(ins_b), .id_two(two_b), .id_pc(pc_b),
    .skp_req(skp_b), .br_req(br_b), .br_adr(bra_b));

  // Synchronous program memories with 1-cycle read latency
  always @(posedge clk) begin
    if (ren_a) rdt_a <= mem_a[adr_a];
    if (ren_b) rdt_b <= mem_b[adr_b];
  end

  // Handover logs
  int          lpc_a[$];
  logic [31:0] lins_a[$];
  logic        ltwo_a[$];
  int          lpc_b[$];
  logic [31:0] lins_b[$];

  always @(negedge clk) begin
    if (vld_a && rdy_a) begin
      lpc_a.push_back(int'(pc_a));
      lins_a.push_back(ins_a);
      ltwo_a.push_back(two_a);
    end
    if (vld_b && rdy_b) begin
      lpc_b.push_back(int'(pc_b));
      lins_b.push_back(ins_b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_a(input int pc, input int bound);
    int n;
    n = 0;
    while (!(vld_a && int'(pc_a) == pc) && n < bound) begin
      step();
      n++;
    end
    chk($sformatf("wait_a_pc_%0h", pc), 64'(vld_a && int'(pc_a) == pc), 64'd1);
  endtask

  task automatic wait_b(input int pc, input int bound);
    int n;
    n = 0;
    while (!(vld_b && int'(pc_b) == pc) && n < bound) begin
      step();
      n++;
    end
    chk($sformatf("wait_b_pc_%0h", pc), 64'(vld_b && int'(pc_b) == pc), 64'd1);
  endtask

  initial begin
    int          e_pc[$];
    logic [31:0] e_ins[$];
    logic        e_two[$];
    int          e_nxt;
    logic [31:0] e_nxt_ins;
    int          eb_pc[$];
    logic [31:0] eb_ins[$];

    for (int i = 0; i < (1 << PA); i++) mem_a[i] = 16'(i);
    mem_a[4] = 16'h940C;
    mem_a[5] = 16'h1234;
    mem_a[8] = 16'h940E;
    mem_a[9] = 16'h5678;
    for (int i = 0; i < (1 << PB); i++) mem_b[i] = 16'h0100 | 16'(i);

    rst_a = 1'b1; rdy_a = 1'b1; skp_a = 1'b0; br_a = 1'b0; bra_a = '0;
    rst_b = 1'b1; rdy_b = 1'b1; skp_b = 1'b0; br_b = 1'b0; bra_b = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ren", 64'(ren_a), 64'd0);
    chk("rst_vld", 64'(vld_a), 64'd0);
    chk("rst_ins", 64'(ins_a), 64'd0);
    chk("rst_two", 64'(two_a), 64'd0);
    chk("rst_pc",  64'(pc_a),  64'd0);

    // Reset release: one read per cycle, first valid two cycles later
    rst_a = 1'b0;
    #1;
    chk("c0_ren", 64'(ren_a), 64'd1);
    chk("c0_adr", 64'(adr_a), 64'd0);
    chk("c0_vld", 64'(vld_a), 64'd0);
    step();
    chk("c1_adr", 64'(adr_a), 64'd1);
    chk("c1_vld", 64'(vld_a), 64'd0);
    step();
    chk("c2_vld", 64'(vld_a), 64'd1);
    chk("c2_pc",  64'(pc_a),  64'd0);
    chk("c2_ins", 64'(ins_a), 64'd0);
    chk("c2_adr", 64'(adr_a), 64'd2);
    step();
    chk("c3_vld", 64'(vld_a), 64'd1);
    chk("c3_pc",  64'(pc_a),  64'd1);
    step();
    chk("c4_pc",  64'(pc_a),  64'd2);
    chk("c4_ins", 64'(ins_a), 64'd2);

    // Skip requested in the handover cycle of pc 7; mem[8] is a call
    wait_a(7, 30);
    skp_a = 1'b1;
    step();
    skp_a = 1'b0;

`ifdef RP_8BIT_FETCH_TWO_WORD_EN
    e_pc  = '{0, 1, 2, 3, 4, 6, 7};
    e_ins = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h1234940C, 32'h6, 32'h7};
    e_two = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_nxt = 10;
    e_nxt_ins = 32'h0000000A;
`else
    e_pc  = '{0, 1, 2, 3, 4, 5, 6, 7};
    e_ins = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h940C, 32'h1234, 32'h6, 32'h7};
    e_two = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e_nxt = 9;
    e_nxt_ins = 32'h00005678;
`endif

    // Backpressure on the first instruction after the skipped one
    wait_a(e_nxt, 20);
    rdy_a = 1'b0;
    chk("seq_len", 64'(lpc_a.size()), 64'(e_pc.size()));
    for (int i = 0; i < e_pc.size() && i < lpc_a.size(); i++) begin
      chk($sformatf("seq_pc[%0d]", i),  64'(lpc_a[i]),  64'(e_pc[i]));
      chk($sformatf("seq_ins[%0d]", i), 64'(lins_a[i]), 64'(e_ins[i]));
      chk($sformatf("seq_two[%0d]", i), 64'(ltwo_a[i]), 64'(e_two[i]));
    end
    lpc_a.delete();
    lins_a.delete();
    ltwo_a.delete();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_vld[%0d]", k), 64'(vld_a), 64'd1);
      chk($sformatf("hold_pc[%0d]", k),  64'(pc_a),  64'(e_nxt));
      chk($sformatf("hold_ins[%0d]", k), 64'(ins_a), 64'(e_nxt_ins));
      step();
    end
    rdy_a = 1'b1;
    wait_a(e_nxt + 4, 20);
    chk("bp_len", 64'(lpc_a.size()), 64'd4);
    for (int k = 0; k < 4 && k < lpc_a.size(); k++) begin
      chk($sformatf("bp_pc[%0d]", k),  64'(lpc_a[k]),  64'(e_nxt + k));
      chk($sformatf("bp_ins[%0d]", k), 64'(lins_a[k]), 64'({16'h0, mem_a[e_nxt + k]}));
    end

    // Branch with a read in flight, together with a skip request
    rdy_a = 1'b0;
    br_a  = 1'b1;
    bra_a = 11'h040;
    skp_a = 1'b1;
    #1;
    chk("br_ren", 64'(ren_a), 64'd1);
    chk("br_adr", 64'(adr_a), 64'h040);
    chk("br_vld", 64'(vld_a), 64'd0);
    step();
    br_a  = 1'b0;
    skp_a = 1'b0;
    rdy_a = 1'b1;
    lpc_a.delete();
    lins_a.delete();
    ltwo_a.delete();
    chk("br_next_vld", 64'(vld_a), 64'd0);
    wait_a(32'h042, 10);
    chk("br_len", 64'(lpc_a.size()), 64'd2);
    if (lpc_a.size() >= 2) begin
      chk("br_pc0",  64'(lpc_a[0]),  64'h040);
      chk("br_ins0", 64'(lins_a[0]), 64'h0040);
      chk("br_pc1",  64'(lpc_a[1]),  64'h041);
    end

    // PAW=4: wrap from 14, then reset mid-stream
    chk("b_rst_ren", 64'(ren_b), 64'd0);
    rst_b = 1'b0;
    #1;
    chk("b_c0_adr", 64'(adr_b), 64'd14);
    chk("b_c0_ren", 64'(ren_b), 64'd1);
    wait_b(1, 10);
    chk("b_len", 64'(lpc_b.size()), 64'd3);
    if (lpc_b.size() >= 3) begin
      chk("b_pc0", 64'(lpc_b[0]), 64'd14);
      chk("b_pc1", 64'(lpc_b[1]), 64'd15);
      chk("b_pc2", 64'(lpc_b[2]), 64'd0);
      chk("b_ins2", 64'(lins_b[2]), 64'h0100);
    end
    rst_b = 1'b1;
    step();
    chk("b_mrst_vld", 64'(vld_b), 64'd0);
    chk("b_mrst_ren", 64'(ren_b), 64'd0);
    chk("b_mrst_ins", 64'(ins_b), 64'd0);
    chk("b_mrst_pc",  64'(pc_b),  64'd0);
    chk("b_mrst_two", 64'(two_b), 64'd0);
    mem_b[15] = 16'h940C;
    mem_b[0]  = 16'hABCD;
    lpc_b.delete();
    lins_b.delete();
    step();
    rst_b = 1'b0;
    #1;
    chk("b_re_adr", 64'(adr_b), 64'd14);
    wait_b(1, 12);
    chk("b_re_ins1", 64'(ins_b), 64'h0101);
`ifdef RP_8BIT_FETCH_TWO_WORD_EN
    eb_pc  = '{14, 15};
    eb_ins = '{32'h010E, 32'hABCD940C};
`else
    eb_pc  = '{14, 15, 0};
    eb_ins = '{32'h010E, 32'h940C, 32'hABCD};
`endif
    chk("b_re_len", 64'(lpc_b.size()), 64'(eb_pc.size()));
    for (int i = 0; i < eb_pc.size() && i < lpc_b.size(); i++) begin
      chk($sformatf("b_re_pc[%0d]", i),  64'(lpc_b[i]),  64'(eb_pc[i]));
      chk($sformatf("b_re_ins[%0d]", i), 64'(lins_b[i]), 64'(eb_ins[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
